// File: rtl/axi4_stream_upsizer_if.sv
// AXI4-Stream bundle shared by the narrow and wide sides of the upsizer.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1
) ();
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
                  input  tready);
  modport slave  (input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
                  output tready);
endinterface

// File: rtl/axi4_stream_upsizer.sv
// Packs RATIO narrow AXI4-Stream beats into one registered wide beat.
// Lane 0 holds the earliest beat; tlast closes a word early and zero-fills
// the unused upper lanes. The accumulator is independent of the output
// register so the next word keeps assembling while the output is stalled.
module axi4_stream_upsizer #(
  parameter int TDATA_WIDTH = 32,
  parameter int RATIO       = 4,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  axi4_stream_if.slave  pkt_i,
  axi4_stream_if.master pkt_o
);
  localparam int KEEP_W    = TDATA_WIDTH / 8;
  localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int ACC_LANES = RATIO - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [ACC_LANES*TDATA_WIDTH-1:0]   acc_data_q, acc_data_d;
  logic [ACC_LANES*KEEP_W-1:0]        acc_keep_q, acc_keep_d;
  logic [ACC_LANES*KEEP_W-1:0]        acc_strb_q, acc_strb_d;
  logic [ACC_LANES*TUSER_WIDTH-1:0]   acc_user_q, acc_user_d;
  logic [TID_WIDTH-1:0]               acc_id_q, acc_id_d;
  logic [TDEST_WIDTH-1:0]             acc_dest_q, acc_dest_d;

  logic [RATIO*TDATA_WIDTH-1:0]       out_data_q, out_data_d;
  logic [RATIO*KEEP_W-1:0]            out_keep_q, out_keep_d;
  logic [RATIO*KEEP_W-1:0]            out_strb_q, out_strb_d;
  logic [RATIO*TUSER_WIDTH-1:0]       out_user_q, out_user_d;
  logic [TID_WIDTH-1:0]               out_id_q, out_id_d;
  logic [TDEST_WIDTH-1:0]             out_dest_q, out_dest_d;
  logic                               out_last_q, out_last_d;
  logic                               out_valid_q, out_valid_d;

  logic out_free;
  logic in_ready;
  logic beat_accept;
  logic beat_closing;

  // Handshake decode: only a closing beat needs room in the output register.
  always_comb begin
    out_free     = !out_valid_q || pkt_o.tready;
    in_ready     = out_free || ((cnt_q != LAST_CNT) && !pkt_i.tlast);
    beat_accept  = pkt_i.tvalid && in_ready;
    beat_closing = (cnt_q == LAST_CNT) || pkt_i.tlast;
  end

  // Next-state: accumulate non-closing beats, assemble the wide word on a closing beat.
  always_comb begin
    cnt_d      = cnt_q;
    acc_data_d = acc_data_q;
    acc_keep_d = acc_keep_q;
    acc_strb_d = acc_strb_q;
    acc_user_d = acc_user_q;
    acc_id_d   = acc_id_q;
    acc_dest_d = acc_dest_q;
    out_data_d = out_data_q;
    out_keep_d = out_keep_q;
    out_strb_d = out_strb_q;
    out_user_d = out_user_q;
    out_id_d   = out_id_q;
    out_dest_d = out_dest_q;
    out_last_d = out_last_q;

    if (out_valid_q && pkt_o.tready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (beat_accept && beat_closing) begin
      out_data_d = {(RATIO*TDATA_WIDTH){1'b0}};
      out_keep_d = {(RATIO*KEEP_W){1'b0}};
      out_strb_d = {(RATIO*KEEP_W){1'b0}};
      out_user_d = {(RATIO*TUSER_WIDTH){1'b0}};
      // Lanes already collected come from the accumulator.
      for (int k = 0; k < ACC_LANES; k++) begin
        if (CNT_W'(k) < cnt_q) begin
          out_data_d[k*TDATA_WIDTH +: TDATA_WIDTH] = acc_data_q[k*TDATA_WIDTH +: TDATA_WIDTH];
          out_keep_d[k*KEEP_W +: KEEP_W]           = acc_keep_q[k*KEEP_W +: KEEP_W];
          out_strb_d[k*KEEP_W +: KEEP_W]           = acc_strb_q[k*KEEP_W +: KEEP_W];
          out_user_d[k*TUSER_WIDTH +: TUSER_WIDTH] = acc_user_q[k*TUSER_WIDTH +: TUSER_WIDTH];
        end else begin
          out_data_d[k*TDATA_WIDTH +: TDATA_WIDTH] = {TDATA_WIDTH{1'b0}};
        end
      end
      // The closing beat lands in lane cnt.
      for (int k = 0; k < RATIO; k++) begin
        if (CNT_W'(k) == cnt_q) begin
          out_data_d[k*TDATA_WIDTH +: TDATA_WIDTH] = pkt_i.tdata;
          out_keep_d[k*KEEP_W +: KEEP_W]           = pkt_i.tkeep;
          out_strb_d[k*KEEP_W +: KEEP_W]           = pkt_i.tstrb;
          out_user_d[k*TUSER_WIDTH +: TUSER_WIDTH] = pkt_i.tuser;
        end else begin
          out_last_d = pkt_i.tlast;
        end
      end
      // A one-beat word takes its routing fields directly from the beat.
      if (cnt_q == {CNT_W{1'b0}}) begin
        out_id_d   = pkt_i.tid;
        out_dest_d = pkt_i.tdest;
      end else begin
        out_id_d   = acc_id_q;
        out_dest_d = acc_dest_q;
      end
      out_last_d  = pkt_i.tlast;
      out_valid_d = 1'b1;
      cnt_d       = {CNT_W{1'b0}};
    end else if (beat_accept) begin
      for (int k = 0; k < ACC_LANES; k++) begin
        if (CNT_W'(k) == cnt_q) begin
          acc_data_d[k*TDATA_WIDTH +: TDATA_WIDTH] = pkt_i.tdata;
          acc_keep_d[k*KEEP_W +: KEEP_W]           = pkt_i.tkeep;
          acc_strb_d[k*KEEP_W +: KEEP_W]           = pkt_i.tstrb;
          acc_user_d[k*TUSER_WIDTH +: TUSER_WIDTH] = pkt_i.tuser;
        end else begin
          acc_data_d[k*TDATA_WIDTH +: TDATA_WIDTH] = acc_data_q[k*TDATA_WIDTH +: TDATA_WIDTH];
        end
      end
      // Routing fields of a word are those of its lane-0 beat.
      if (cnt_q == {CNT_W{1'b0}}) begin
        acc_id_d   = pkt_i.tid;
        acc_dest_d = pkt_i.tdest;
      end else begin
        acc_id_d   = acc_id_q;
        acc_dest_d = acc_dest_q;
      end
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset discards any partial word and empties the output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= {CNT_W{1'b0}};
      acc_data_q  <= {(ACC_LANES*TDATA_WIDTH){1'b0}};
      acc_keep_q  <= {(ACC_LANES*KEEP_W){1'b0}};
      acc_strb_q  <= {(ACC_LANES*KEEP_W){1'b0}};
      acc_user_q  <= {(ACC_LANES*TUSER_WIDTH){1'b0}};
      acc_id_q    <= {TID_WIDTH{1'b0}};
      acc_dest_q  <= {TDEST_WIDTH{1'b0}};
      out_data_q  <= {(RATIO*TDATA_WIDTH){1'b0}};
      out_keep_q  <= {(RATIO*KEEP_W){1'b0}};
      out_strb_q  <= {(RATIO*KEEP_W){1'b0}};
      out_user_q  <= {(RATIO*TUSER_WIDTH){1'b0}};
      out_id_q    <= {TID_WIDTH{1'b0}};
      out_dest_q  <= {TDEST_WIDTH{1'b0}};
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_data_q  <= acc_data_d;
      acc_keep_q  <= acc_keep_d;
      acc_strb_q  <= acc_strb_d;
      acc_user_q  <= acc_user_d;
      acc_id_q    <= acc_id_d;
      acc_dest_q  <= acc_dest_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_strb_q  <= out_strb_d;
      out_user_q  <= out_user_d;
      out_id_q    <= out_id_d;
      out_dest_q  <= out_dest_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign pkt_i.tready = in_ready;
  assign pkt_o.tvalid = out_valid_q;
  assign pkt_o.tdata  = out_data_q;
  assign pkt_o.tkeep  = out_keep_q;
  assign pkt_o.tstrb  = out_strb_q;
  assign pkt_o.tuser  = out_user_q;
  assign pkt_o.tid    = out_id_q;
  assign pkt_o.tdest  = out_dest_q;
  assign pkt_o.tlast  = out_last_q;
endmodule

// File: tb/tb_axi4_stream_upsizer.sv
// Self-checking bench for axi4_stream_upsizer (RATIO=4, 32-bit narrow side).
module tb_axi4_stream_upsizer;
  localparam int W   = 32;
  localparam int R   = 4;
  localparam int KW  = W / 8;
  localparam int UW  = 1;
  localparam int IW  = 2;
  localparam int DW  = 2;
  localparam int OW  = W * R;
  localparam int OKW = KW * R;
  localparam int OUW = UW * R;

  typedef struct {
    logic [W-1:0]  d;
    logic [KW-1:0] k;
    logic [KW-1:0] s;
    logic [UW-1:0] u;
    logic [IW-1:0] id;
    logic [DW-1:0] de;
    logic          l;
  } beat_t;

  logic clk_i;
  logic rst_i;

  axi4_stream_if #(.DATA_WIDTH(W),  .USER_WIDTH(UW),  .ID_WIDTH(IW), .DEST_WIDTH(DW)) in_if ();
  axi4_stream_if #(.DATA_WIDTH(OW), .USER_WIDTH(OUW), .ID_WIDTH(IW), .DEST_WIDTH(DW)) out_if ();

  axi4_stream_upsizer #(
    .TDATA_WIDTH(W), .RATIO(R), .TID_WIDTH(IW), .TDEST_WIDTH(DW), .TUSER_WIDTH(UW)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .pkt_i (in_if),
    .pkt_o (out_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: pending narrow beats plus the word the output should show.
  beat_t         bq[$];
  bit            m_full;
  logic [OW-1:0] m_data;
  logic [OKW-1:0] m_keep, m_strb;
  logic [OUW-1:0] m_user;
  logic [IW-1:0] m_id;
  logic [DW-1:0] m_dest;
  logic          m_last;
  int            exp_words;

  logic [OW-1:0]  lg_data[$];
  logic [OKW-1:0] lg_keep[$];
  logic [OUW-1:0] lg_user[$];
  logic           lg_last[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [W-1:0] d, input logic l, input bit rnd_side);
    beat_t b;
    b.d  = d;
    b.l  = l;
    b.k  = rnd_side ? KW'($urandom) : {KW{1'b1}};
    b.s  = rnd_side ? KW'($urandom) : {KW{1'b1}};
    b.u  = UW'($urandom);
    b.id = IW'($urandom);
    b.de = DW'($urandom);
    return b;
  endfunction

  task automatic model_reset();
    bq.delete();
    m_full = 1'b0;
    m_data = '0; m_keep = '0; m_strb = '0; m_user = '0;
    m_id = '0; m_dest = '0; m_last = 1'b0;
  endtask

  // One clock: drive, check against the model, then advance the model.
  task automatic cycle(input beat_t b, input bit v, input bit oready, output bit acc);
    bit closing, exp_rdy;
    @(negedge clk_i);
    in_if.tvalid  = v;
    in_if.tdata   = b.d;
    in_if.tkeep   = b.k;
    in_if.tstrb   = b.s;
    in_if.tuser   = b.u;
    in_if.tid     = b.id;
    in_if.tdest   = b.de;
    in_if.tlast   = b.l;
    out_if.tready = oready;
    #1;
    closing = (bq.size() == R - 1) || b.l;
    exp_rdy = !m_full || oready || !closing;
    chk("in_tready", in_if.tready, exp_rdy);
    chk("out_tvalid", out_if.tvalid, m_full);
    if (m_full) begin
      chk("out_tdata", out_if.tdata, m_data);
      chk("out_tkeep", out_if.tkeep, m_keep);
      chk("out_tstrb", out_if.tstrb, m_strb);
      chk("out_tuser", out_if.tuser, m_user);
      chk("out_tid",   out_if.tid,   m_id);
      chk("out_tdest", out_if.tdest, m_dest);
      chk("out_tlast", out_if.tlast, m_last);
    end
    if (out_if.tvalid === 1'b1 && oready) begin
      lg_data.push_back(out_if.tdata);
      lg_keep.push_back(out_if.tkeep);
      lg_user.push_back(out_if.tuser);
      lg_last.push_back(out_if.tlast);
    end
    if (m_full && oready) m_full = 1'b0;
    acc = v && exp_rdy;
    if (acc) begin
      bq.push_back(b);
      if (closing) begin
        m_data = '0; m_keep = '0; m_strb = '0; m_user = '0;
        for (int k = 0; k < bq.size(); k++) begin
          m_data[k*W +: W]   = bq[k].d;
          m_keep[k*KW +: KW] = bq[k].k;
          m_strb[k*KW +: KW] = bq[k].s;
          m_user[k*UW +: UW] = bq[k].u;
        end
        m_id   = bq[0].id;
        m_dest = bq[0].de;
        m_last = b.l;
        m_full = 1'b1;
        exp_words++;
        bq.delete();
      end
    end
  endtask

  task automatic idle(input int n, input bit oready);
    bit a;
    beat_t z;
    z = mk(32'h0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) cycle(z, 1'b0, oready, a);
  endtask

  task automatic clear_logs();
    lg_data.delete(); lg_keep.delete(); lg_user.delete(); lg_last.delete();
  endtask

  beat_t bs[$];
  beat_t cur;
  bit    a;
  int    idx, n_acc, bound;
  logic [OW-1:0] tmp_w;
  logic [W-1:0]  first_d;

  initial begin
    in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tkeep = '0; in_if.tstrb = '0;
    in_if.tuser = '0; in_if.tid = '0; in_if.tdest = '0; in_if.tlast = 1'b0;
    out_if.tready = 1'b0;
    exp_words = 0;
    model_reset();

    // Reset state
    rst_i = 1'b1;
    #12;
    chk("rst_tvalid", out_if.tvalid, 1'b0);
    chk("rst_tready", in_if.tready, 1'b1);
    chk("rst_tdata",  out_if.tdata, 128'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Eight full beats, no tlast
    clear_logs();
    for (int i = 1; i <= 8; i++) cycle(mk(W'(i * 17), 1'b0, 1'b0), 1'b1, 1'b1, a);
    idle(2, 1'b1);
    chk("t1_words", lg_data.size(), 2);
    tmp_w = lg_data[0];
    chk("t1_word0", tmp_w, 128'h00000044_00000033_00000022_00000011);
    tmp_w = lg_data[1];
    chk("t1_word1", tmp_w, 128'h00000088_00000077_00000066_00000055);
    chk("t1_keep", lg_keep[0], 16'hFFFF);
    chk("t1_last", lg_last[1], 1'b0);

    // Three beats closed by tlast
    clear_logs();
    cycle(mk(32'hAAAA_AAAA, 1'b0, 1'b0), 1'b1, 1'b1, a);
    cycle(mk(32'hBBBB_BBBB, 1'b0, 1'b0), 1'b1, 1'b1, a);
    cycle(mk(32'hCCCC_CCCC, 1'b1, 1'b0), 1'b1, 1'b1, a);
    idle(2, 1'b1);
    tmp_w = lg_data[0];
    chk("t2_word", tmp_w, 128'h00000000_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    chk("t2_keep", lg_keep[0], 16'h0FFF);
    chk("t2_last", lg_last[0], 1'b1);

    // Single beat with tlast at lane 0
    clear_logs();
    cur = mk(32'h1234_5678, 1'b1, 1'b0);
    cur.u = 1'b1;
    cycle(cur, 1'b1, 1'b1, a);
    idle(2, 1'b1);
    chk("t3_keep", lg_keep[0], 16'h000F);
    chk("t3_user", lg_user[0], 4'b0001);

    // Output stalled for 10 cycles while 8 beats are offered
    clear_logs();
    bs.delete();
    for (int i = 0; i < 8; i++) bs.push_back(mk(W'($urandom), 1'b0, 1'b1));
    idx = 0; n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(bs[idx], idx < 8, 1'b0, a);
      if (a) begin idx++; n_acc++; end
    end
    chk("t4_stall_accepted", n_acc, 7);
    bound = 0;
    while ((idx < 8 || m_full) && bound < 30) begin
      if (idx < 8) cycle(bs[idx], 1'b1, 1'b1, a);
      else idle(1, 1'b1);
      if (a && idx < 8) idx++;
      a = 1'b0;
      bound++;
    end
    chk("t4_done_in_bound", bound < 30, 1'b1);
    chk("t4_words", lg_data.size(), 2);

    // Continuous traffic, sink always ready
    clear_logs();
    n_acc = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(mk(W'($urandom), 1'b0, 1'b1), 1'b1, 1'b1, a);
      if (a) n_acc++;
    end
    idle(2, 1'b1);
    chk("t5_all_accepted", n_acc, 32);
    chk("t5_words", lg_data.size(), 8);

    // Random valid, tlast and backpressure
    cur = mk(W'($urandom), ($urandom_range(0, 4) == 0), 1'b1);
    for (int i = 0; i < 300; i++) begin
      cycle(cur, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), a);
      if (a) cur = mk(W'($urandom), ($urandom_range(0, 4) == 0), 1'b1);
    end
    idle(3, 1'b1);

    // Reset with a full output word and a half-built word
    clear_logs();
    for (int i = 0; i < 6; i++) cycle(mk(W'($urandom), 1'b0, 1'b1), 1'b1, 1'b0, a);
    @(negedge clk_i);
    in_if.tvalid = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("t6_rst_tvalid", out_if.tvalid, 1'b0);
    chk("t6_rst_tready", in_if.tready, 1'b1);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    cur = mk(32'hFEED_0001, 1'b0, 1'b1);
    first_d = cur.d;
    cycle(cur, 1'b1, 1'b1, a);
    for (int i = 0; i < 3; i++) cycle(mk(W'($urandom), 1'b0, 1'b1), 1'b1, 1'b1, a);
    idle(2, 1'b1);
    chk("t6_words", lg_data.size(), 1);
    tmp_w = lg_data[0];
    chk("t6_lane0", tmp_w[W-1:0], first_d);

    chk("end_idle", out_if.tvalid, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
